// File: rtl/vaddsws_pkg.sv
// Shared constants for the saturating signed word adder.
package vaddsws_pkg;

  // Default element width of one lane.
  localparam int WIDTH_DEF = 32;

  // Clamp values for a 32-bit signed lane.
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SMIN = 32'h8000_0000;

endpackage

// File: rtl/vaddsws_sat_add.sv
// Combinational saturating signed adder for one lane.
module sat_add
  import vaddsws_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);

  // Largest and smallest representable values at this width; these equal
  // SMAX/SMIN for the 32-bit lane.
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  // The exact sum needs one guard bit. It overflows the lane exactly when the
  // guard bit and the lane MSB disagree, which only happens for same-sign
  // operands. The guard bit then gives the true sign of the sum.
  function automatic logic [WIDTH:0] saturate(input logic signed [WIDTH:0] s);
    logic [WIDTH:0] r;
    if (s[WIDTH] != s[WIDTH-1]) begin
      r = {1'b1, (s[WIDTH] ? MINV : MAXV)};
    end else begin
      r = {1'b0, s[WIDTH-1:0]};
    end
    return r;
  endfunction

  logic signed [WIDTH:0] sum;
  logic        [WIDTH:0] res;

  // Exact sign-extended sum followed by clamping to the lane range.
  always_comb begin
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    res = saturate(sum);
    ovf = res[WIDTH];
    y   = res[WIDTH-1:0];
  end

endmodule

// File: rtl/vaddsws.sv
// One 32-bit lane of the saturating signed vector word add, one-cycle latency.
module vaddsws
  import vaddsws_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] vra,
  input  logic signed [WIDTH-1:0] vrb,
  output logic                    vrt_en,
  output logic signed [WIDTH-1:0] vrt,
  output logic                    sat
);

  logic signed [WIDTH-1:0] add_y;
  logic                    add_ovf;

  logic signed [WIDTH-1:0] vrt_d,    vrt_q;
  logic                    sat_d,    sat_q;
  logic                    vrt_en_d, vrt_en_q;

  sat_add #(
    .WIDTH (WIDTH)
  ) u_sat_add (
    .a   (vra),
    .b   (vrb),
    .y   (add_y),
    .ovf (add_ovf)
  );

  // Capture a new result on en; otherwise hold the last result and drop valid.
  // Operands are ignored when en is low so nothing unknown reaches the outputs.
  always_comb begin
    vrt_d    = vrt_q;
    sat_d    = sat_q;
    vrt_en_d = 1'b0;
    if (en) begin
      vrt_d    = add_y;
      sat_d    = add_ovf;
      vrt_en_d = 1'b1;
    end
  end

  // Output register stage; reset clears everything and overrides en.
  always_ff @(posedge clk) begin
    if (rst) begin
      vrt_q    <= '0;
      sat_q    <= 1'b0;
      vrt_en_q <= 1'b0;
    end else begin
      vrt_q    <= vrt_d;
      sat_q    <= sat_d;
      vrt_en_q <= vrt_en_d;
    end
  end

  assign vrt    = vrt_q;
  assign sat    = sat_q;
  assign vrt_en = vrt_en_q;

endmodule

// File: tb/tb_vaddsws.sv
// Self-checking bench for vaddsws: directed corner cases then random traffic.
module tb_vaddsws;
  import vaddsws_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] vra = '0;
  logic [31:0] vrb = '0;
  logic        vrt_en;
  logic [31:0] vrt;
  logic        sat;

  int checks = 0;
  int errors = 0;

  // Reference expectation of the registered outputs.
  logic [31:0] m_vrt    = '0;
  logic        m_sat    = 1'b0;
  logic        m_vrt_en = 1'b0;

  vaddsws #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .vra    (vra),
    .vrb    (vrb),
    .vrt_en (vrt_en),
    .vrt    (vrt),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  // Exact integer sum clamped to the signed 32-bit range; bit 32 is the flag.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647)       return {1'b1, SMAX};
    else if (s < -64'sd2147483648) return {1'b1, SMIN};
    else                           return {1'b0, s[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference, and compare all outputs after the edge.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [31:0] a, input logic [31:0] b);
    logic [32:0] rr;
    @(negedge clk);
    rst = r; en = e; vra = a; vrb = b;
    rr = ref_add(a, b);
    if (r) begin
      m_vrt = '0; m_sat = 1'b0; m_vrt_en = 1'b0;
    end else if (e) begin
      m_vrt = rr[31:0]; m_sat = rr[32]; m_vrt_en = 1'b1;
    end else begin
      m_vrt_en = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ".vrt"},    vrt,           m_vrt);
    check({tag, ".sat"},    {31'b0, sat},    {31'b0, m_sat});
    check({tag, ".vrt_en"}, {31'b0, vrt_en}, {31'b0, m_vrt_en});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = SMAX;
      1:       v = SMIN;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h0000_0001;
      4:       v = {1'b0, 31'($urandom)} | 32'h4000_0000;
      5:       v = {1'b1, 31'($urandom)} & 32'hBFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    // Reset state.
    step("reset0", 1'b1, 1'b0, 32'h0, 32'h0);
    step("reset1", 1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111);
    check("reset_vrt_zero", vrt, 32'h0);

    // Simple sum, first op after reset with no warm-up.
    step("add_5_3", 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0003);
    check("add_5_3_const", vrt, 32'h0000_0008);
    check("add_5_3_sat", {31'b0, sat}, 32'h0);
    check("add_5_3_vld", {31'b0, vrt_en}, 32'h1);

    // Positive overflow.
    step("pos_ovf_a", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
    check("pos_ovf_a_const", vrt, 32'h7FFF_FFFF);
    check("pos_ovf_a_sat", {31'b0, sat}, 32'h1);
    step("pos_ovf_b", 1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000);
    check("pos_ovf_b_const", vrt, 32'h7FFF_FFFF);

    // Negative overflow and mixed-sign extremes.
    step("neg_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("neg_ovf_const", vrt, 32'h8000_0000);
    check("neg_ovf_sat", {31'b0, sat}, 32'h1);
    step("mixed_ext", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    check("mixed_ext_const", vrt, 32'hFFFF_FFFF);
    check("mixed_ext_sat", {31'b0, sat}, 32'h0);

    // Back-to-back saturating then non-saturating, then idle holds.
    step("b2b_sat", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    check("b2b_sat_flag", {31'b0, sat}, 32'h1);
    step("b2b_nosat", 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002);
    check("b2b_nosat_flag", {31'b0, sat}, 32'h0);
    step("idle0", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check("idle0_hold", vrt, 32'h0000_0003);
    check("idle0_vld", {31'b0, vrt_en}, 32'h0);
    step("idle1", 1'b0, 1'b0, $urandom, $urandom);
    step("sat_then_idle", 1'b0, 1'b1, 32'h7000_0000, 32'h7000_0000);
    step("idle_hold_sat", 1'b0, 1'b0, 32'h0, 32'h0);
    check("idle_hold_sat_flag", {31'b0, sat}, 32'h1);

    // Reset beats a saturating operation in the same cycle.
    step("rst_vs_en", 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check("rst_vs_en_vrt", vrt, 32'h0);
    check("rst_vs_en_sat", {31'b0, sat}, 32'h0);
    step("post_rst", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("post_rst_const", vrt, 32'hFFFF_FFFE);

    // Random traffic: mostly back-to-back, with idles and rare resets.
    for (int i = 0; i < 10000; i++) begin
      logic r, e;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) < 8);
      step("rand", r, e, pick_operand(), pick_operand());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vaddsws.md
VADDSWS -- requirements
Module: vaddsws

Interface
REQ-001 Parameter WIDTH, default 32: element width in bits; only 32 is required to be supported.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  operand-valid strobe; 1 = compute and register a result this cycle.
REQ-005 vra  input  WIDTH  operand A, two's-complement signed.
REQ-006 vrb  input  WIDTH  operand B, two's-complement signed.
REQ-007 vrt_en  output  1  result-valid, high for exactly one cycle per accepted operation.
REQ-008 vrt  output  WIDTH  saturated signed sum, registered.
REQ-009 sat  output  1  saturation flag for the result currently on vrt, registered.

Function
REQ-010 The block SHALL form the exact signed sum S = vra + vrb at WIDTH+1 bits, with no wrap-around.
REQ-011 The block SHALL detect positive overflow when vra[MSB]=0, vrb[MSB]=0 and the WIDTH-bit sum MSB=1, and SHALL then produce 0x7FFFFFFF with sat=1.
REQ-012 The block SHALL detect negative overflow when vra[MSB]=1, vrb[MSB]=1 and the WIDTH-bit sum MSB=0, and SHALL then produce 0x80000000 with sat=1.
REQ-013 Otherwise the block SHALL produce the WIDTH-bit sum unchanged with sat=0; operands of opposite sign SHALL never saturate.
REQ-014 Latency SHALL be exactly 1 cycle: with en=1 at rising edge N, vrt, sat and vrt_en=1 SHALL be valid after edge N.
REQ-015 With en=0 at an edge, vrt_en SHALL go to 0, and vrt and sat SHALL hold their previous values.
REQ-016 The block SHALL accept back-to-back operations (en=1 every cycle), giving one result per cycle in order, with no stall and no backpressure.
REQ-017 sat SHALL be per-result and not sticky; accumulation into a status register is the integrator's responsibility.
REQ-018 No X SHALL propagate to the outputs when en=0, regardless of vra and vrb values.

Reset
REQ-019 When rst=1 at a rising edge, the block SHALL set vrt=0, sat=0 and vrt_en=0.
REQ-020 rst SHALL take priority over en; an operation presented in the same cycle as rst SHALL be discarded.
REQ-021 After rst is deasserted, the first en=1 cycle SHALL behave per REQ-014, with no warm-up cycles.

Structure
REQ-022 A shared package SHALL hold the WIDTH default and the constants SMAX (0x7FFFFFFF) and SMIN (0x80000000).
REQ-023 The combinational saturating adder SHALL be a sub-module named sat_add with ports a, b, y and ovf.
REQ-024 vaddsws SHALL instantiate sat_add and add only the output register stage and the control logic.
REQ-025 Four instances of vaddsws SHALL compose the 128-bit word add; sat is ORed across lanes outside this block.

Verification
REQ-026 vra=0x00000005, vrb=0x00000003, en=1 -> next cycle vrt=0x00000008, sat=0, vrt_en=1.
REQ-027 vra=0x7FFFFFFF, vrb=0x00000001 -> vrt=0x7FFFFFFF, sat=1; vra=0x40000000, vrb=0x40000000 -> vrt=0x7FFFFFFF, sat=1.
REQ-028 vra=0x80000000, vrb=0xFFFFFFFF -> vrt=0x80000000, sat=1; vra=0x7FFFFFFF, vrb=0x80000000 -> vrt=0xFFFFFFFF, sat=0.
REQ-029 Back-to-back operations: saturating then non-saturating -> sat is 1 then 0 on consecutive cycles; then en=0 -> vrt_en=0 and vrt/sat hold.
REQ-030 Assert rst during an en=1 cycle with saturating operands -> vrt=0, sat=0, vrt_en=0 after that edge.
REQ-031 Random test: 10k operand pairs checked against a 33-bit reference model clamped to [SMIN, SMAX].
